// File: rtl/alu_accumulator.sv
// alu_accumulator: 8-bit accumulator ALU (ADD/ADC/SUB/LOAD) with a three-state IDLE/EXEC/DONE sequencer
module eightBitAdder (
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       c_in,
    output logic [7:0] sum,
    output logic       c_out,
    output logic       overflow
);
    assign {c_out, sum} = {1'b0, x} + {1'b0, y} + {8'b0, c_in};
    assign overflow = (x[7] == y[7]) && (sum[7] != x[7]);
endmodule

module alu_accumulator (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] op,
    input  logic [7:0] operand,
    output logic [7:0] acc,
    output logic       carry_flag,
    output logic       overflow_flag,
    output logic       zero_flag,
    output logic       negative_flag,
    output logic       busy,
    output logic       done
);
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] EXEC = 2'b01;
    localparam logic [1:0] DONE = 2'b10;
    localparam logic [1:0] OP_ADC  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    logic [1:0] state;
    logic [1:0] op_r;
    logic [7:0] operand_r;
    logic [7:0] y;
    logic       c_in;
    logic [7:0] sum;
    logic       c_out;
    logic       ovf;
    logic [7:0] result;

    eightBitAdder u_adder (
        .x        (acc),
        .y        (y),
        .c_in     (c_in),
        .sum      (sum),
        .c_out    (c_out),
        .overflow (ovf)
    );

    // SUB is acc + ~operand + 1; ADC chains in the carry held from the previous op
    always_comb begin
        y      = (op_r == OP_SUB) ? ~operand_r : operand_r;
        c_in   = (op_r == OP_SUB) ? 1'b1 : (op_r == OP_ADC) ? carry_flag : 1'b0;
        result = (op_r == OP_LOAD) ? operand_r : sum;
    end

    assign busy = (state == EXEC) || (state == DONE);
    assign done = (state == DONE);

    // Sequencer: latch request in IDLE, commit result and flags in EXEC, pulse done in DONE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            op_r          <= 2'b00;
            operand_r     <= 8'h00;
            acc           <= 8'h00;
            carry_flag    <= 1'b0;
            overflow_flag <= 1'b0;
            zero_flag     <= 1'b0;
            negative_flag <= 1'b0;
        end else if (state == IDLE) begin
            if (start) begin
                op_r      <= op;
                operand_r <= operand;
                state     <= EXEC;
            end
        end else if (state == EXEC) begin
            acc           <= result;
            carry_flag    <= (op_r == OP_LOAD) ? 1'b0 : c_out;
            overflow_flag <= (op_r == OP_LOAD) ? 1'b0 : ovf;
            zero_flag     <= (result == 8'h00);
            negative_flag <= result[7];
            state         <= DONE;
        end else begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_alu_accumulator.sv
// tb_alu_accumulator: directed and randomized checks of alu_accumulator against an arithmetic model
module tb_alu_accumulator;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [1:0] op = 2'b00;
    logic [7:0] operand = 8'h00;
    logic [7:0] acc;
    logic       carry_flag, overflow_flag, zero_flag, negative_flag, busy, done;

    int checks = 0;
    int failures = 0;

    logic [7:0] acc_m = 8'h00;
    logic       c_m = 1'b0, v_m = 1'b0, z_m = 1'b0, n_m = 1'b0;

    alu_accumulator dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .op            (op),
        .operand       (operand),
        .acc           (acc),
        .carry_flag    (carry_flag),
        .overflow_flag (overflow_flag),
        .zero_flag     (zero_flag),
        .negative_flag (negative_flag),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".acc"}, acc, acc_m);
        check({tag, ".C"}, {7'b0, carry_flag}, {7'b0, c_m});
        check({tag, ".V"}, {7'b0, overflow_flag}, {7'b0, v_m});
        check({tag, ".Z"}, {7'b0, zero_flag}, {7'b0, z_m});
        check({tag, ".N"}, {7'b0, negative_flag}, {7'b0, n_m});
    endtask

    // Reference: signed/unsigned integer arithmetic, result taken modulo 256
    task automatic model_op(input logic [1:0] o, input logic [7:0] d);
        int ua, ud, sa, sd, r, sr;
        ua = acc_m;
        ud = d;
        sa = $signed(acc_m);
        sd = $signed(d);
        r = 0;
        sr = 0;
        if (o == 2'd3) begin
            r = ud;
            c_m = 1'b0;
            v_m = 1'b0;
        end else begin
            if (o == 2'd2) begin
                r = ua - ud;
                sr = sa - sd;
                c_m = (ua >= ud);
            end else begin
                r = ua + ud + ((o == 2'd1) ? int'(c_m) : 0);
                sr = sa + sd + ((o == 2'd1) ? int'(c_m) : 0);
                c_m = (r > 255);
            end
            v_m = (sr > 127) || (sr < -128);
        end
        acc_m = 8'(r & 255);
        z_m = (acc_m == 8'h00);
        n_m = acc_m[7];
    endtask

    task automatic do_op(input string tag, input logic [1:0] o, input logic [7:0] d);
        start = 1'b1;
        op = o;
        operand = d;
        @(posedge clk); #1;
        check({tag, ".busy1"}, {7'b0, busy}, 8'd1);
        check({tag, ".done1"}, {7'b0, done}, 8'd0);
        start = 1'b0;
        op = 2'($urandom);
        operand = 8'($urandom);
        model_op(o, d);
        @(posedge clk); #1;
        check({tag, ".done2"}, {7'b0, done}, 8'd1);
        check_regs(tag);
        @(posedge clk); #1;
        check({tag, ".done3"}, {7'b0, done}, 8'd0);
        check({tag, ".busy3"}, {7'b0, busy}, 8'd0);
        check_regs({tag, ".hold"});
    endtask

    int done_cnt;
    int first_done, second_done;

    initial begin
        op = 2'b11;
        operand = 8'hA5;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("rst.busy", {7'b0, busy}, 8'd0);
        check("rst.done", {7'b0, done}, 8'd0);
        check_regs("rst");
        @(posedge clk); #1;
        reset = 1'b0;

        do_op("r30.load", 2'd3, 8'h7F);
        do_op("r30.add", 2'd0, 8'h01);
        do_op("r31.load", 2'd3, 8'hFF);
        do_op("r31.add", 2'd0, 8'h01);
        do_op("r31.adc", 2'd1, 8'h00);
        do_op("r32.load", 2'd3, 8'h05);
        do_op("r32.sub", 2'd2, 8'h05);
        do_op("r32.sub80", 2'd2, 8'h80);
        check("r32.fixed_acc", acc, 8'h80);

        for (int i = 0; i < 40; i++)
            do_op($sformatf("rnd%0d", i), 2'($urandom_range(0, 3)), 8'($urandom));

        do_op("r33.load", 2'd3, 8'h00);
        start = 1'b1;
        op = 2'd0;
        operand = 8'h01;
        done_cnt = 0;
        first_done = -1;
        second_done = -1;
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk); #1;
            if (done) begin
                done_cnt++;
                if (first_done < 0) first_done = e; else second_done = e;
            end
        end
        start = 1'b0;
        for (int e = 7; e <= 10; e++) begin
            @(posedge clk); #1;
            if (done) done_cnt++;
        end
        model_op(2'd0, 8'h01);
        model_op(2'd0, 8'h01);
        check("r33.done_cnt", 8'(done_cnt), 8'd2);
        check("r33.spacing", 8'(second_done - first_done), 8'd3);
        check_regs("r33");

        do_op("r34.load", 2'd3, 8'h10);
        start = 1'b1;
        op = 2'd0;
        operand = 8'h01;
        @(posedge clk); #1;
        start = 1'b0;
        check("r34.exec_busy", {7'b0, busy}, 8'd1);
        #2;
        reset = 1'b1;
        #1;
        acc_m = 8'h00; c_m = 1'b0; v_m = 1'b0; z_m = 1'b0; n_m = 1'b0;
        check("r34.busy", {7'b0, busy}, 8'd0);
        check("r34.done", {7'b0, done}, 8'd0);
        check_regs("r34");
        @(posedge clk); #1;
        reset = 1'b0;
        done_cnt = 0;
        for (int e = 0; e < 4; e++) begin
            @(posedge clk); #1;
            if (done) done_cnt++;
        end
        check("r34.no_done", 8'(done_cnt), 8'd0);
        check_regs("r34.after");

        do_op("post.add", 2'd0, 8'h33);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
